// File: rtl/image_sequencer_fsm_if.sv
// -----------------------------------------------------------------------------
// image_sequencer_fsm_if
//
// Purpose: bundles the handshakes between the image sequencer and its three
// neighbours: the UART-fed config storage, the A-line transmit FSM and the
// acquisition memory.
//
// Signals:
//   cfg_valid  config storage holds a complete configuration
//   cfg_busy   config storage is intaking or updating
//   dly_req    sequencer requests per-channel delays for dly_aline
//   dly_aline  A-line index for the delay fetch
//   dly_ack    delays are presented to the transmitter
//   tx_start   one-cycle pulse that fires the A-line transmitter
//   tx_busy    A-line transmitter active
//   tx_done    one-cycle pulse, A-line complete
//   mem_clear  acquisition memory ready for the next A-line
//
// Modports: master = sequencer side, slave = peripheral side.
// -----------------------------------------------------------------------------
interface image_sequencer_fsm_if #(
  parameter int ALINE_W = 4
);
  logic               cfg_valid;
  logic               cfg_busy;
  logic               dly_req;
  logic [ALINE_W-1:0] dly_aline;
  logic               dly_ack;
  logic               tx_start;
  logic               tx_busy;
  logic               tx_done;
  logic               mem_clear;

  modport master (
    input  cfg_valid, cfg_busy, dly_ack, tx_busy, tx_done, mem_clear,
    output dly_req, dly_aline, tx_start
  );

  modport slave (
    output cfg_valid, cfg_busy, dly_ack, tx_busy, tx_done, mem_clear,
    input  dly_req, dly_aline, tx_start
  );
endinterface

// File: rtl/image_sequencer_fsm.sv
// -----------------------------------------------------------------------------
// image_sequencer_fsm
//
// Purpose: steps an ultrasound image through num_alines A-lines per frame and
// num_frames frames (0 = run continuously). For every A-line it fetches the
// per-channel delays, fires the A-line transmitter, waits a programmable
// settle time and then waits for acquisition memory to clear. Supports abort,
// multi-frame operation and a sticky error flag. All outputs are registered.
//
// Optional build macro: IMAGE_SEQ_WATCHDOG_EN
//   When defined, a watchdog counts cycles spent in WAIT_TX; reaching
//   TX_TIMEOUT cycles without tx_done sets error, pulses aborted and returns
//   to IDLE. The TX_TIMEOUT parameter only exists in that build.
//
// Ports:
//   clk                     system clock (posedge)
//   rst                     asynchronous active-high reset
//   start_i                 image request, level sampled in IDLE
//   abort_i                 stop request, sampled every cycle
//   num_alines_i            A-lines per frame (ALINE_W+1 bits, 0 is illegal)
//   num_frames_i            frames per image (0 = continuous)
//   settle_cycles_i         dead time after each A-line
//   seq                     handshake bundle (master modport)
//   busy_o                  start cannot be accepted
//   transmit_in_progress_o  high in any non-IDLE state
//   current_aline_o         A-line index in progress
//   current_frame_o         frame index in progress
//   current_state_o         state encoding for debug
//   frame_done_o            one-cycle pulse at the end of each frame
//   image_done_o            one-cycle pulse at normal completion
//   aborted_o               one-cycle pulse on abort return to IDLE
//   error_o                 sticky error flag
// -----------------------------------------------------------------------------
module image_sequencer_fsm #(
  parameter int ALINE_W  = 4,
  parameter int FRAME_W  = 8,
  parameter int SETTLE_W = 16
`ifdef IMAGE_SEQ_WATCHDOG_EN
  , parameter int TX_TIMEOUT = 65535
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [ALINE_W:0]    num_alines_i,
  input  logic [FRAME_W-1:0]  num_frames_i,
  input  logic [SETTLE_W-1:0] settle_cycles_i,
  image_sequencer_fsm_if.master seq,
  output logic                busy_o,
  output logic                transmit_in_progress_o,
  output logic [ALINE_W-1:0]  current_aline_o,
  output logic [FRAME_W-1:0]  current_frame_o,
  output logic [2:0]          current_state_o,
  output logic                frame_done_o,
  output logic                image_done_o,
  output logic                aborted_o,
  output logic                error_o
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REQ_DELAYS = 3'd1,
    S_START_TX   = 3'd2,
    S_WAIT_TX    = 3'd3,
    S_SETTLE     = 3'd4,
    S_WAIT_MEM   = 3'd5
  } state_t;

  state_t              state_q;
  logic [ALINE_W-1:0]  aline_q;
  logic [ALINE_W-1:0]  last_aline_q;
  logic [FRAME_W-1:0]  frame_q;
  logic [FRAME_W-1:0]  last_frame_q;
  logic                continuous_q;
  logic [SETTLE_W-1:0] settle_len_q;
  logic [SETTLE_W-1:0] settle_cnt_q;
  logic                abort_pend_q;

  logic                dly_req_q;
  logic [ALINE_W-1:0]  dly_aline_q;
  logic                tx_start_q;
  logic                busy_q;
  logic                tip_q;
  logic                frame_done_q;
  logic                image_done_q;
  logic                aborted_q;
  logic                error_q;

`ifdef IMAGE_SEQ_WATCHDOG_EN
  localparam int WD_W = (TX_TIMEOUT < 2) ? 1 : $clog2(TX_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TX_TIMEOUT - 1);
  logic [WD_W-1:0] wd_cnt_q;
`endif

  // Neighbours not ready: start must be refused.
  logic src_busy_d;
  logic last_aline_d;
  logic last_frame_d;
  logic abort_now_d;

  assign src_busy_d   = seq.cfg_busy | seq.tx_busy | ~seq.cfg_valid;
  assign last_aline_d = (aline_q == last_aline_q);
  assign last_frame_d = ~continuous_q & (frame_q == last_frame_q);
  // Abort seen now or earlier while the transmitter could not be interrupted.
  assign abort_now_d  = abort_pend_q | abort_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      aline_q      <= '0;
      last_aline_q <= '0;
      frame_q      <= '0;
      last_frame_q <= '0;
      continuous_q <= 1'b0;
      settle_len_q <= '0;
      settle_cnt_q <= '0;
      abort_pend_q <= 1'b0;
      dly_req_q    <= 1'b0;
      dly_aline_q  <= '0;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      tip_q        <= 1'b0;
      frame_done_q <= 1'b0;
      image_done_q <= 1'b0;
      aborted_q    <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMAGE_SEQ_WATCHDOG_EN
      wd_cnt_q     <= '0;
`endif
    end else begin
      // Pulses default low; busy/in-progress default to the non-IDLE value
      // and every path that lands in IDLE overrides them.
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      image_done_q <= 1'b0;
      aborted_q    <= 1'b0;
      busy_q       <= 1'b1;
      tip_q        <= 1'b1;

      case (state_q)
        S_IDLE: begin
          busy_q <= src_busy_d;
          tip_q  <= 1'b0;
          if (start_i && !src_busy_d) begin
            if (num_alines_i == '0) begin
              error_q <= 1'b1;
            end else begin
              last_aline_q <= ALINE_W'(num_alines_i - (ALINE_W+1)'(1));
              last_frame_q <= num_frames_i - FRAME_W'(1);
              continuous_q <= (num_frames_i == '0);
              settle_len_q <= settle_cycles_i;
              error_q      <= 1'b0;
              aline_q      <= '0;
              frame_q      <= '0;
              abort_pend_q <= 1'b0;
              busy_q       <= 1'b1;
              tip_q        <= 1'b1;
              state_q      <= S_REQ_DELAYS;
            end
          end
        end

        // First cycle raises dly_req; dly_ack is honoured only while the
        // request is visible to the config storage.
        S_REQ_DELAYS: begin
          if (abort_i) begin
            dly_req_q <= 1'b0;
            aborted_q <= 1'b1;
            busy_q    <= src_busy_d;
            tip_q     <= 1'b0;
            state_q   <= S_IDLE;
          end else if (!dly_req_q) begin
            dly_req_q   <= 1'b1;
            dly_aline_q <= aline_q;
          end else if (seq.dly_ack) begin
            dly_req_q  <= 1'b0;
            tx_start_q <= 1'b1;
            state_q    <= S_START_TX;
          end
        end

        S_START_TX: begin
          abort_pend_q <= abort_now_d;
          state_q      <= S_WAIT_TX;
`ifdef IMAGE_SEQ_WATCHDOG_EN
          wd_cnt_q     <= '0;
`endif
        end

        // mem_clear is deliberately not looked at here; WAIT_MEM re-samples it.
        S_WAIT_TX: begin
          if (seq.tx_done) begin
            if (abort_now_d) begin
              abort_pend_q <= 1'b0;
              aborted_q    <= 1'b1;
              busy_q       <= src_busy_d;
              tip_q        <= 1'b0;
              state_q      <= S_IDLE;
            end else if (settle_len_q == '0) begin
              state_q <= S_WAIT_MEM;
            end else begin
              settle_cnt_q <= settle_len_q - SETTLE_W'(1);
              state_q      <= S_SETTLE;
            end
          end else begin
            abort_pend_q <= abort_now_d;
`ifdef IMAGE_SEQ_WATCHDOG_EN
            if (wd_cnt_q == WD_LAST) begin
              abort_pend_q <= 1'b0;
              error_q      <= 1'b1;
              aborted_q    <= 1'b1;
              busy_q       <= src_busy_d;
              tip_q        <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
`endif
          end
        end

        // Counter starts at settle-1 so exactly settle_cycles cycles are spent here.
        S_SETTLE: begin
          if (abort_i) begin
            aborted_q <= 1'b1;
            busy_q    <= src_busy_d;
            tip_q     <= 1'b0;
            state_q   <= S_IDLE;
          end else if (settle_cnt_q == '0) begin
            state_q <= S_WAIT_MEM;
          end else begin
            settle_cnt_q <= settle_cnt_q - SETTLE_W'(1);
          end
        end

        S_WAIT_MEM: begin
          if (abort_i) begin
            aborted_q <= 1'b1;
            busy_q    <= src_busy_d;
            tip_q     <= 1'b0;
            state_q   <= S_IDLE;
          end else if (seq.mem_clear) begin
            if (!last_aline_d) begin
              aline_q <= aline_q + ALINE_W'(1);
              state_q <= S_REQ_DELAYS;
            end else begin
              frame_done_q <= 1'b1;
              aline_q      <= '0;
              if (last_frame_d) begin
                image_done_q <= 1'b1;
                frame_q      <= '0;
                busy_q       <= src_busy_d;
                tip_q        <= 1'b0;
                state_q      <= S_IDLE;
              end else begin
                // Wraps naturally in continuous mode.
                frame_q <= frame_q + FRAME_W'(1);
                state_q <= S_REQ_DELAYS;
              end
            end
          end
        end

        default: begin
          dly_req_q <= 1'b0;
          busy_q    <= src_busy_d;
          tip_q     <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign seq.dly_req             = dly_req_q;
  assign seq.dly_aline           = dly_aline_q;
  assign seq.tx_start            = tx_start_q;
  assign busy_o                  = busy_q;
  assign transmit_in_progress_o  = tip_q;
  assign current_aline_o         = aline_q;
  assign current_frame_o         = frame_q;
  assign current_state_o         = state_q;
  assign frame_done_o            = frame_done_q;
  assign image_done_o            = image_done_q;
  assign aborted_o               = aborted_q;
  assign error_o                 = error_q;

endmodule

// File: tb/tb_image_sequencer_fsm.sv
module tb_image_sequencer_fsm;
  localparam int ALINE_W  = 4;
  localparam int FRAME_W  = 8;
  localparam int SETTLE_W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                start_i, abort_i;
  logic [ALINE_W:0]    num_alines_i;
  logic [FRAME_W-1:0]  num_frames_i;
  logic [SETTLE_W-1:0] settle_cycles_i;
  logic                busy, tip, frame_done, image_done, aborted, error;
  logic [ALINE_W-1:0]  cur_aline;
  logic [FRAME_W-1:0]  cur_frame;
  logic [2:0]          cur_state;

  image_sequencer_fsm_if #(.ALINE_W(ALINE_W)) bus ();

  image_sequencer_fsm #(
    .ALINE_W(ALINE_W), .FRAME_W(FRAME_W), .SETTLE_W(SETTLE_W)
`ifdef IMAGE_SEQ_WATCHDOG_EN
    , .TX_TIMEOUT(20)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .num_alines_i(num_alines_i), .num_frames_i(num_frames_i),
    .settle_cycles_i(settle_cycles_i), .seq(bus),
    .busy_o(busy), .transmit_in_progress_o(tip),
    .current_aline_o(cur_aline), .current_frame_o(cur_frame),
    .current_state_o(cur_state), .frame_done_o(frame_done),
    .image_done_o(image_done), .aborted_o(aborted), .error_o(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // {state, dly_req, tx_start, frame_done, image_done, aborted, error, busy}
  function automatic logic [9:0] pack_out();
    return {cur_state, bus.dly_req, bus.tx_start, frame_done, image_done, aborted, error, busy};
  endfunction

  // Vector record: in = {start, abort, dly_ack, tx_done, mem_clear}
  typedef struct {
    logic [4:0] in;
    logic [4:0] nal;
    logic [9:0] exp;
    logic [3:0] dal;
    logic [3:0] cal;
  } vec_t;
  vec_t tbl[23];

  // Responder bookkeeping
  int n_txs, n_fd, n_imd, n_abt, settle_run;
  int frame_log[$];
  int dal_log[$];
  int settle_log[$];
  logic dreq_prev;

  task automatic clear_counts();
    n_txs = 0; n_fd = 0; n_imd = 0; n_abt = 0; settle_run = 0; dreq_prev = 1'b0;
    frame_log.delete(); dal_log.delete(); settle_log.delete();
  endtask

  // One clock with a well-behaved config store and transmitter model.
  task automatic cycle_resp(input bit tx_en);
    bus.dly_ack = bus.dly_req;
    bus.tx_done = tx_en && (cur_state == 3'd3);
    @(posedge clk); #1;
    if (bus.tx_start) begin n_txs++; frame_log.push_back(int'(cur_frame)); end
    if (bus.dly_req && !dreq_prev) dal_log.push_back(int'(bus.dly_aline));
    dreq_prev = bus.dly_req;
    if (cur_state == 3'd4) settle_run++;
    else if (settle_run != 0) begin settle_log.push_back(settle_run); settle_run = 0; end
    if (frame_done) n_fd++;
    if (image_done) n_imd++;
    if (aborted) n_abt++;
  endtask

  // mode 0: until state==tgt; mode 1: until image_done/aborted; mode 2: until n_fd==tgt
  task automatic run_until(input int mode, input int tgt, input bit tx_en, input int budget, output bit hit);
    hit = 1'b0;
    for (int c = 0; c < budget && !hit; c++) begin
      cycle_resp(tx_en);
      if (mode == 0)      hit = (int'(cur_state) == tgt);
      else if (mode == 1) hit = image_done || aborted;
      else                hit = (n_fd == tgt);
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    cycle_resp(1'b1);
    start_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit hit;
    int wd_cycles;
    logic [31:0] act_v, exp_v;

    // 3 A-lines / 1 frame / settle 0, then num_alines=0 error, abort in REQ_DELAYS, abort in IDLE
    tbl[0]  = '{5'b10001, 5'd3, 10'b001_0_0_0_0_0_0_1, 4'd0, 4'd0};
    tbl[1]  = '{5'b00001, 5'd3, 10'b001_1_0_0_0_0_0_1, 4'd0, 4'd0};
    tbl[2]  = '{5'b00101, 5'd3, 10'b010_0_1_0_0_0_0_1, 4'd0, 4'd0};
    tbl[3]  = '{5'b00001, 5'd3, 10'b011_0_0_0_0_0_0_1, 4'd0, 4'd0};
    tbl[4]  = '{5'b00011, 5'd3, 10'b101_0_0_0_0_0_0_1, 4'd0, 4'd0};
    tbl[5]  = '{5'b00001, 5'd3, 10'b001_0_0_0_0_0_0_1, 4'd0, 4'd1};
    tbl[6]  = '{5'b00001, 5'd3, 10'b001_1_0_0_0_0_0_1, 4'd1, 4'd1};
    tbl[7]  = '{5'b00101, 5'd3, 10'b010_0_1_0_0_0_0_1, 4'd1, 4'd1};
    tbl[8]  = '{5'b00001, 5'd3, 10'b011_0_0_0_0_0_0_1, 4'd1, 4'd1};
    tbl[9]  = '{5'b00011, 5'd3, 10'b101_0_0_0_0_0_0_1, 4'd1, 4'd1};
    tbl[10] = '{5'b00001, 5'd3, 10'b001_0_0_0_0_0_0_1, 4'd2, 4'd2};
    tbl[11] = '{5'b00001, 5'd3, 10'b001_1_0_0_0_0_0_1, 4'd2, 4'd2};
    tbl[12] = '{5'b00101, 5'd3, 10'b010_0_1_0_0_0_0_1, 4'd2, 4'd2};
    tbl[13] = '{5'b00001, 5'd3, 10'b011_0_0_0_0_0_0_1, 4'd2, 4'd2};
    tbl[14] = '{5'b00011, 5'd3, 10'b101_0_0_0_0_0_0_1, 4'd2, 4'd2};
    tbl[15] = '{5'b00001, 5'd3, 10'b000_0_0_1_1_0_0_0, 4'd0, 4'd0};
    tbl[16] = '{5'b00001, 5'd3, 10'b000_0_0_0_0_0_0_0, 4'd0, 4'd0};
    tbl[17] = '{5'b10001, 5'd0, 10'b000_0_0_0_0_0_1_0, 4'd0, 4'd0};
    tbl[18] = '{5'b00001, 5'd0, 10'b000_0_0_0_0_0_1_0, 4'd0, 4'd0};
    tbl[19] = '{5'b10001, 5'd3, 10'b001_0_0_0_0_0_0_1, 4'd0, 4'd0};
    tbl[20] = '{5'b01001, 5'd3, 10'b000_0_0_0_0_1_0_0, 4'd0, 4'd0};
    tbl[21] = '{5'b01001, 5'd3, 10'b000_0_0_0_0_0_0_0, 4'd0, 4'd0};
    tbl[22] = '{5'b00001, 5'd3, 10'b000_0_0_0_0_0_0_0, 4'd0, 4'd0};

    rst = 1'b1;
    start_i = 1'b0; abort_i = 1'b0;
    num_alines_i = 5'd3; num_frames_i = 8'd1; settle_cycles_i = 16'd0;
    bus.cfg_valid = 1'b1; bus.cfg_busy = 1'b0; bus.tx_busy = 1'b0;
    bus.dly_ack = 1'b0; bus.tx_done = 1'b0; bus.mem_clear = 1'b1;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {13'd0, pack_out(), tip, cur_aline, cur_frame},
          32'd0);
    rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 23; i++) begin
      {start_i, abort_i, bus.dly_ack, bus.tx_done, bus.mem_clear} = tbl[i].in;
      num_alines_i = tbl[i].nal;
      @(posedge clk); #1;
      act_v = {14'd0, pack_out(), cur_aline, (tbl[i].exp[6] ? bus.dly_aline : 4'h0)};
      exp_v = {14'd0, tbl[i].exp, tbl[i].cal, (tbl[i].exp[6] ? tbl[i].dal : 4'h0)};
      check($sformatf("vec%0d", i), act_v, exp_v);
    end
    start_i = 1'b0; abort_i = 1'b0; bus.dly_ack = 1'b0; bus.tx_done = 1'b0; bus.mem_clear = 1'b1;

    // ---------------- 2 A-lines x 2 frames, settle 5 ----------------
    clear_counts();
    num_alines_i = 5'd2; num_frames_i = 8'd2; settle_cycles_i = 16'd5;
    pulse_start();
    run_until(1, 0, 1'b1, 200, hit);
    check("A_finished", 32'(hit), 32'd1);
    check("A_tx_count", 32'(n_txs), 32'd4);
    check("A_frame_done", 32'(n_fd), 32'd2);
    check("A_image_done", 32'(n_imd), 32'd1);
    check("A_settle_runs", 32'(settle_log.size()), 32'd4);
    check("A_settle0", 32'(settle_log[0]), 32'd5);
    check("A_settle3", 32'(settle_log[3]), 32'd5);
    check("A_frames", {frame_log[0][7:0], frame_log[1][7:0], frame_log[2][7:0], frame_log[3][7:0]},
          32'h00000101);
    check("A_idle", {29'd0, cur_state}, 32'd0);

    // ---------------- continuous, 1 A-line, abort in WAIT_TX ----------------
    clear_counts();
    num_alines_i = 5'd1; num_frames_i = 8'd0; settle_cycles_i = 16'd0;
    pulse_start();
    run_until(2, 3, 1'b1, 100, hit);
    check("B_three_frames", 32'(hit), 32'd1);
    check("B_frame_idx", 32'(cur_frame), 32'd3);
    check("B_no_image_done", 32'(n_imd), 32'd0);
    run_until(0, 3, 1'b0, 20, hit);
    check("B_reach_wait_tx", 32'(hit), 32'd1);
    abort_i = 1'b1;
    cycle_resp(1'b0);
    abort_i = 1'b0;
    repeat (3) cycle_resp(1'b0);
    check("B_pending_holds", {29'd0, cur_state}, 32'd3);
    check("B_no_abort_yet", 32'(n_abt), 32'd0);
    cycle_resp(1'b1);
    check("B_abort_exit", {22'd0, pack_out()}, {22'd0, 10'b000_0_0_0_0_1_0_0});
    check("B_frame_done_count", 32'(n_fd), 32'd3);

    // ---------------- start while cfg_busy; mem_clear held low ----------------
    clear_counts();
    bus.cfg_busy = 1'b1;
    num_alines_i = 5'd1; num_frames_i = 8'd1; settle_cycles_i = 16'd3;
    pulse_start();
    check("C_busy_ignored", {22'd0, pack_out()}, {22'd0, 10'b000_0_0_0_0_0_0_1});
    bus.cfg_busy = 1'b0;
    cycle_resp(1'b1);
    check("C_busy_released", 32'(busy), 32'd0);
    bus.mem_clear = 1'b0;
    pulse_start();
    run_until(0, 5, 1'b1, 30, hit);
    check("C_reach_wait_mem", 32'(hit), 32'd1);
    check("C_settle_len", 32'(settle_log[0]), 32'd3);
    repeat (10) cycle_resp(1'b1);
    check("C_stays_wait_mem", {28'd0, tip, cur_state}, {28'd0, 1'b1, 3'd5});
    bus.mem_clear = 1'b1;
    run_until(1, 0, 1'b1, 10, hit);
    check("C_completes", {30'd0, image_done, frame_done}, 32'd3);

    // ---------------- num_alines = 2^ALINE_W ----------------
    clear_counts();
    num_alines_i = 5'd16; num_frames_i = 8'd1; settle_cycles_i = 16'd0;
    pulse_start();
    run_until(1, 0, 1'b1, 400, hit);
    check("D_finished", 32'(hit), 32'd1);
    check("D_tx_count", 32'(n_txs), 32'd16);
    check("D_dly_count", 32'(dal_log.size()), 32'd16);
    check("D_last_aline", 32'(dal_log[15]), 32'd15);
    check("D_done_pulses", {30'd0, image_done, frame_done}, 32'd3);

`ifdef IMAGE_SEQ_WATCHDOG_EN
    // ---------------- watchdog, tx_done never arrives ----------------
    clear_counts();
    num_alines_i = 5'd1; num_frames_i = 8'd1; settle_cycles_i = 16'd0;
    pulse_start();
    run_until(0, 3, 1'b0, 20, hit);
    check("W_reach_wait_tx", 32'(hit), 32'd1);
    wd_cycles = 1;
    for (int c = 0; c < 100 && cur_state == 3'd3; c++) begin
      cycle_resp(1'b0);
      if (cur_state == 3'd3) wd_cycles++;
    end
    check("W_cycles", 32'(wd_cycles), 32'd20);
    check("W_exit", {22'd0, pack_out()}, {22'd0, 10'b000_0_0_0_0_1_1_0});
`endif

    // ---------------- async reset mid-operation ----------------
    clear_counts();
    num_alines_i = 5'd2; num_frames_i = 8'd1; settle_cycles_i = 16'd0;
    pulse_start();
    run_until(0, 3, 1'b0, 20, hit);
    check("E_reach_wait_tx", 32'(hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("E_async_reset",
          {9'd0, pack_out(), tip, bus.dly_aline, cur_aline, cur_frame},
          32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("E_after_reset", {22'd0, pack_out()}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/image_sequencer_fsm.md
Name: image_sequencer_fsm

Overview:
Parametrised successor to the single-frame image transmit sequencer. Steps an ultrasound image through N A-lines per frame and M frames (or runs continuously), for each A-line: requests per-channel delays from config storage, fires the A-line transmitter, applies a programmable settle time, and waits for acquisition memory to clear. Sits between the UART-fed config storage, the A-line transmit FSM and the acquisition memory. Adds abort, multi-frame and error reporting. Fully synchronous to posedge clk.

Parameters:
ALINE_W, 4, width of A-line index; up to 2^ALINE_W A-lines per frame
FRAME_W, 8, width of frame count
SETTLE_W, 16, width of inter-A-line settle counter
TX_TIMEOUT, 65535, watchdog limit in cycles (used only with watchdog compiled in)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  request image, level sampled in IDLE
abort  in  1  stop request, sampled every cycle
num_alines  in  ALINE_W+1  A-lines per frame, latched at start; 0 illegal
num_frames  in  FRAME_W  frames per image, latched at start; 0 = continuous
settle_cycles  in  SETTLE_W  dead time after each A-line, latched at start
cfg_valid  in  1  config storage holds a complete configuration
cfg_busy  in  1  config storage intaking or updating
dly_req  out  1  request delays for dly_aline
dly_aline  out  ALINE_W  A-line index for delay fetch
dly_ack  in  1  delays presented to transmitter
tx_start  out  1  one-cycle pulse to A-line transmitter
tx_busy  in  1  A-line transmitter active
tx_done  in  1  one-cycle pulse, A-line complete
mem_clear  in  1  acquisition memory ready for next A-line
busy  out  1  start cannot be accepted
transmit_in_progress  out  1  high in any non-IDLE state
current_aline  out  ALINE_W  A-line index in progress
current_frame  out  FRAME_W  frame index in progress
current_state  out  3  state encoding for debug
frame_done  out  1  one-cycle pulse at end of each frame
image_done  out  1  one-cycle pulse at normal completion
aborted  out  1  one-cycle pulse on abort return to IDLE
error  out  1  sticky error flag

Behaviour:
- All outputs registered; reset values: all 0, state IDLE.
- States: IDLE=0, REQ_DELAYS=1, START_TX=2, WAIT_TX=3, SETTLE=4, WAIT_MEM=5.
- IDLE: busy = cfg_busy|tx_busy|~cfg_valid. start & ~busy & num_alines!=0 -> latch params, clear error, aline=frame=0, REQ_DELAYS. start & ~busy & num_alines==0 -> error=1, stay IDLE. start while busy ignored.
- Latency: start sampled at edge N -> dly_req high after edge N+1.
- REQ_DELAYS: dly_req=1, dly_aline=current_aline; hold until dly_ack; dly_req drops on the edge that leaves -> START_TX.
- START_TX: tx_start=1 exactly one cycle -> WAIT_TX.
- WAIT_TX: wait tx_done. settle==0 -> WAIT_MEM; else SETTLE with counter=settle_cycles-1.
- SETTLE: count down to 0 -> WAIT_MEM (exactly settle_cycles cycles in SETTLE).
- WAIT_MEM: wait mem_clear. Aline not last -> aline+1, REQ_DELAYS. Last aline (aline==num_alines-1) -> frame_done pulse, aline=0; if num_frames!=0 and frame==num_frames-1 -> image_done pulse, IDLE; else frame+1 (wraps at 2^FRAME_W in continuous mode), REQ_DELAYS.
- Abort: in REQ_DELAYS, SETTLE, WAIT_MEM -> IDLE next edge, aborted pulse. In START_TX/WAIT_TX latched as pending; transmitter never cut mid-pulse; IDLE after tx_done with aborted pulse. No frame_done/image_done on abort. Abort in IDLE ignored.
- tx_done and mem_clear in same cycle in WAIT_TX: mem_clear ignored; re-sampled in WAIT_MEM.
- num_alines=2^ALINE_W legal (index reaches max, no overflow).
- Async reset mid-operation: all outputs 0, IDLE immediately; no pulses generated.

Optional Feature:
IMAGE_SEQ_WATCHDOG_EN: when defined, a counter runs in WAIT_TX; reaching TX_TIMEOUT cycles without tx_done sets error=1, pulses aborted, returns to IDLE. When undefined, WAIT_TX waits indefinitely and error is set only by num_alines==0.

Test Plan:
- num_alines=3, num_frames=1, settle=0, mem_clear high -> 3 dly_req/tx_start pairs, dly_aline 0,1,2, one frame_done and image_done on same edge, IDLE.
- num_alines=2, num_frames=2, settle=5 -> 4 tx_start, 5 cycles in SETTLE each, frame_done twice, current_frame 0 then 1.
- num_frames=0, num_alines=1 -> runs continuously; abort in WAIT_TX -> tx_done honoured, then aborted pulse, no image_done.
- start with num_alines=0 -> error=1, no dly_req; next valid start clears error.
- start while cfg_busy=1 -> ignored, busy=1; hold mem_clear low in WAIT_MEM 10 cycles -> stays WAIT_MEM.
- Watchdog build, TX_TIMEOUT=20, tx_done never -> error=1, aborted pulse at cycle 20 in WAIT_TX.
